// File: rtl/load_buffer.sv
// load_buffer: holds address-resolved loads until all older stores commit,
// issues one per cycle to the data-memory port, and registers the
// aligned/extended result for CDB writeback.
module load_buffer #(
  parameter int unsigned LB_SIZE   = 4,
  parameter int unsigned ROB_IDX_W = 5,
  parameter int unsigned STCNT_W   = 3,
  parameter int unsigned XLEN      = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alloc_valid,
  input  logic [XLEN-1:0]      alloc_addr,
  input  logic [1:0]           alloc_size,
  input  logic                 alloc_unsigned,
  input  logic [ROB_IDX_W-1:0] alloc_rob_idx,
  input  logic [STCNT_W-1:0]   alloc_st_cnt,
  input  logic                 commit_wr_mem,
  input  logic                 branch_misprediction,
  input  logic                 lb_exec_stall,
  input  logic                 lb_wr_enable,
  input  logic [XLEN-1:0]      mem2lb_data,
  output logic                 lb_full,
  output logic                 lb_read_mem,
  output logic [XLEN-1:0]      lb2mem_addr,
  output logic                 lb_wr_valid,
  output logic [ROB_IDX_W-1:0] lb_wr_rob_idx,
  output logic [XLEN-1:0]      lb_wr_value
);

  localparam int unsigned IDX_W = (LB_SIZE > 1) ? $clog2(LB_SIZE) : 1;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      addr;
    logic [1:0]           size;
    logic                 is_unsigned;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [STCNT_W-1:0]   st_cnt;
  } entry_t;

  entry_t             ent [LB_SIZE];
  entry_t             iss_ent;
  entry_t             alloc_ent;
  logic [LB_SIZE-1:0] valid_vec;
  logic [LB_SIZE-1:0] ready_vec;
  logic [IDX_W-1:0]   iss_idx;
  logic [IDX_W-1:0]   free_idx;
  logic               has_ready;
  logic               issue;
  logic               alloc_ok;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [XLEN-1:0]    ld_value;

  // Per-entry valid and ready (no older stores outstanding) vectors
  always_comb begin
    valid_vec = '0;
    ready_vec = '0;
    for (int i = 0; i < LB_SIZE; i++) begin
      valid_vec[i] = ent[i].valid;
      ready_vec[i] = ent[i].valid && (ent[i].st_cnt == '0);
    end
  end

  // Lowest-index ready entry for issue and lowest-index free entry for alloc
  always_comb begin
    has_ready = 1'b0;
    iss_idx   = '0;
    free_idx  = '0;
    for (int i = LB_SIZE - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        has_ready = 1'b1;
        iss_idx   = IDX_W'(i);
      end
      if (!valid_vec[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  // Issue/alloc qualification; flush blocks both, full blocks alloc
  always_comb begin
    lb_full     = &valid_vec;
    issue       = has_ready && !lb_exec_stall && !branch_misprediction;
    alloc_ok    = alloc_valid && !lb_full && !branch_misprediction;
    iss_ent     = ent[iss_idx];
    lb_read_mem = issue;
    lb2mem_addr = issue ? {iss_ent.addr[XLEN-1:2], 2'b00} : '0;
  end

  // New entry contents; a same-cycle commit already counts against it
  always_comb begin
    alloc_ent             = '0;
    alloc_ent.valid       = 1'b1;
    alloc_ent.addr        = alloc_addr;
    alloc_ent.size        = alloc_size;
    alloc_ent.is_unsigned = alloc_unsigned;
    alloc_ent.rob_idx     = alloc_rob_idx;
    alloc_ent.st_cnt      = alloc_st_cnt;
    if (commit_wr_mem && (alloc_st_cnt != '0)) begin
      alloc_ent.st_cnt = alloc_st_cnt - STCNT_W'(1);
    end
  end

  // Lane extraction and sign/zero extension of the returned memory word
  always_comb begin
    ld_byte  = mem2lb_data[{iss_ent.addr[1:0], 3'b000} +: 8];
    ld_half  = mem2lb_data[{iss_ent.addr[1], 4'b0000} +: 16];
    ld_value = mem2lb_data;
    case (iss_ent.size)
      2'd0: ld_value = iss_ent.is_unsigned ? XLEN'(ld_byte)
                                           : {{(XLEN-8){ld_byte[7]}}, ld_byte};
      2'd1: ld_value = iss_ent.is_unsigned ? XLEN'(ld_half)
                                           : {{(XLEN-16){ld_half[15]}}, ld_half};
      default: ld_value = mem2lb_data;
    endcase
  end

  // Entry storage: flush > store-count decrement / issue free / alloc
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LB_SIZE; i++) begin
        ent[i] <= '0;
      end
    end else if (branch_misprediction) begin
      for (int i = 0; i < LB_SIZE; i++) begin
        ent[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < LB_SIZE; i++) begin
        if (commit_wr_mem && ent[i].valid && (ent[i].st_cnt != '0)) begin
          ent[i].st_cnt <= ent[i].st_cnt - STCNT_W'(1);
        end
        if (issue && (iss_idx == IDX_W'(i))) begin
          ent[i].valid <= 1'b0;
        end
        if (alloc_ok && (free_idx == IDX_W'(i))) begin
          ent[i] <= alloc_ent;
        end
      end
    end
  end

  // Writeback register: load on issue, release when the CDB accepts it
  always_ff @(posedge clock) begin
    if (reset) begin
      lb_wr_valid   <= 1'b0;
      lb_wr_rob_idx <= '0;
      lb_wr_value   <= '0;
    end else if (branch_misprediction) begin
      lb_wr_valid <= 1'b0;
    end else if (issue) begin
      lb_wr_valid   <= 1'b1;
      lb_wr_rob_idx <= iss_ent.rob_idx;
      lb_wr_value   <= ld_value;
    end else if (lb_wr_enable) begin
      lb_wr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_load_buffer.sv
// Directed self-checking bench for load_buffer.
module tb_load_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        alloc_valid;
  logic [31:0] alloc_addr;
  logic [1:0]  alloc_size;
  logic        alloc_unsigned;
  logic [4:0]  alloc_rob_idx;
  logic [2:0]  alloc_st_cnt;
  logic        commit_wr_mem;
  logic        branch_misprediction;
  logic        lb_exec_stall;
  logic        lb_wr_enable;
  logic [31:0] mem2lb_data;
  logic        lb_full;
  logic        lb_read_mem;
  logic [31:0] lb2mem_addr;
  logic        lb_wr_valid;
  logic [4:0]  lb_wr_rob_idx;
  logic [31:0] lb_wr_value;

  int n_checks = 0;
  int n_errors = 0;

  load_buffer dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_size(alloc_size),
    .alloc_unsigned(alloc_unsigned), .alloc_rob_idx(alloc_rob_idx),
    .alloc_st_cnt(alloc_st_cnt), .commit_wr_mem(commit_wr_mem),
    .branch_misprediction(branch_misprediction), .lb_exec_stall(lb_exec_stall),
    .lb_wr_enable(lb_wr_enable), .mem2lb_data(mem2lb_data),
    .lb_full(lb_full), .lb_read_mem(lb_read_mem), .lb2mem_addr(lb2mem_addr),
    .lb_wr_valid(lb_wr_valid), .lb_wr_rob_idx(lb_wr_rob_idx), .lb_wr_value(lb_wr_value)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reset                = 1'b0;
    alloc_valid          = 1'b0;
    commit_wr_mem        = 1'b0;
    branch_misprediction = 1'b0;
    lb_exec_stall        = 1'b0;
    lb_wr_enable         = 1'b1;
  endtask

  task automatic set_alloc(input logic [31:0] a, input logic [1:0] sz, input logic u,
                           input logic [4:0] rob, input logic [2:0] st);
    alloc_valid    = 1'b1;
    alloc_addr     = a;
    alloc_size     = sz;
    alloc_unsigned = u;
    alloc_rob_idx  = rob;
    alloc_st_cnt   = st;
  endtask

  // alloc -> issue next cycle -> result the cycle after
  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input logic [4:0] rob, input logic [31:0] data,
                         input logic [31:0] exp);
    idle();
    set_alloc(a, sz, u, rob, 3'd0);
    mem2lb_data = data;
    #1;
    check({tag, "_no_early_issue"}, 32'(lb_read_mem), 32'd0);
    tick();
    alloc_valid = 1'b0;
    #1;
    check({tag, "_read_mem"}, 32'(lb_read_mem), 32'd1);
    check({tag, "_mem_addr"}, lb2mem_addr, {a[31:2], 2'b00});
    tick();
    check({tag, "_wr_valid"}, 32'(lb_wr_valid), 32'd1);
    check({tag, "_wr_rob"}, 32'(lb_wr_rob_idx), 32'(rob));
    check({tag, "_wr_value"}, lb_wr_value, exp);
    tick();
    check({tag, "_wr_released"}, 32'(lb_wr_valid), 32'd0);
  endtask

  initial begin
    idle();
    alloc_addr = '0; alloc_size = '0; alloc_unsigned = 1'b0;
    alloc_rob_idx = '0; alloc_st_cnt = '0; mem2lb_data = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_full", 32'(lb_full), 32'd0);
    check("rst_read_mem", 32'(lb_read_mem), 32'd0);
    check("rst_mem_addr", lb2mem_addr, 32'd0);
    check("rst_wr_valid", 32'(lb_wr_valid), 32'd0);
    check("rst_wr_rob", 32'(lb_wr_rob_idx), 32'd0);
    check("rst_wr_value", lb_wr_value, 32'd0);
    tick();

    // Basic word load and extraction cases
    do_load("word", 32'h104, 2'd2, 1'b0, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF);
    do_load("byte_s", 32'h203, 2'd0, 1'b0, 5'd4, 32'h80112233, 32'hFFFFFF80);
    do_load("byte_u", 32'h203, 2'd0, 1'b1, 5'd5, 32'h80112233, 32'h00000080);
    do_load("half_s", 32'h202, 2'd1, 1'b0, 5'd6, 32'h80002233, 32'hFFFF8000);
    do_load("half_u0", 32'h201, 2'd1, 1'b1, 5'd7, 32'h80002233, 32'h00002233);
    do_load("byte_s1", 32'h301, 2'd0, 1'b0, 5'd8, 32'h80112233, 32'h00000022);

    // Older-store wait: st_cnt 2, commits on non-consecutive cycles
    idle();
    set_alloc(32'h400, 2'd2, 1'b0, 5'd9, 3'd2);
    mem2lb_data = 32'h12345678;
    tick();
    idle(); commit_wr_mem = 1'b1; lb_exec_stall = 1'b1; #1;
    check("st_commit1_no_issue", 32'(lb_read_mem), 32'd0);
    tick();
    idle(); #1;
    check("st_cnt1_not_ready", 32'(lb_read_mem), 32'd0);
    tick();
    idle(); commit_wr_mem = 1'b1; lb_exec_stall = 1'b1; #1;
    check("st_commit2_no_issue", 32'(lb_read_mem), 32'd0);
    tick();
    idle(); #1;
    check("st_ready_issue", 32'(lb_read_mem), 32'd1);
    check("st_issue_addr", lb2mem_addr, 32'h400);
    tick();
    check("st_wr_rob", 32'(lb_wr_rob_idx), 32'd9);
    check("st_wr_value", lb_wr_value, 32'h12345678);
    tick();

    // Fill all entries, drop overflow alloc, drain in index order
    for (int i = 0; i < 4; i++) begin
      idle();
      set_alloc(32'h10 + 32'(4 * i), 2'd2, 1'b0, 5'(8 + i), 3'd1);
      tick();
    end
    idle(); #1;
    check("fill_full", 32'(lb_full), 32'd1);
    set_alloc(32'h50, 2'd2, 1'b0, 5'd12, 3'd0);
    tick();
    idle(); commit_wr_mem = 1'b1; #1;
    check("fill_overflow_dropped_full", 32'(lb_full), 32'd1);
    check("fill_commit_no_issue", 32'(lb_read_mem), 32'd0);
    tick();
    idle(); mem2lb_data = 32'hA5A5_0000; #1;
    check("drain0_read", 32'(lb_read_mem), 32'd1);
    check("drain0_addr", lb2mem_addr, 32'h10);
    check("drain0_full", 32'(lb_full), 32'd1);
    tick();
    for (int i = 1; i < 4; i++) begin
      mem2lb_data = 32'hA5A5_0000 + 32'(i);
      #1;
      check("drain_read", 32'(lb_read_mem), 32'd1);
      check("drain_addr", lb2mem_addr, 32'h10 + 32'(4 * i));
      check("drain_full", 32'(lb_full), 32'd0);
      check("drain_prev_rob", 32'(lb_wr_rob_idx), 32'(8 + i - 1));
      check("drain_prev_val", lb_wr_value, 32'hA5A5_0000 + 32'(i - 1));
      tick();
    end
    #1;
    check("drain_done_no_issue", 32'(lb_read_mem), 32'd0);
    check("drain_last_rob", 32'(lb_wr_rob_idx), 32'd11);
    tick();

    // Writeback hold under lb_wr_enable=0, simultaneous alloc+issue
    idle();
    set_alloc(32'h40, 2'd2, 1'b0, 5'd1, 3'd0);
    mem2lb_data = 32'h1111_1111;
    tick();
    set_alloc(32'h44, 2'd2, 1'b0, 5'd2, 3'd0);
    #1;
    check("hold_issue1", 32'(lb_read_mem), 32'd1);
    check("hold_issue1_addr", lb2mem_addr, 32'h40);
    tick();
    for (int k = 0; k < 2; k++) begin
      idle(); lb_wr_enable = 1'b0; lb_exec_stall = 1'b1; mem2lb_data = 32'h9999_9999; #1;
      check("hold_no_issue", 32'(lb_read_mem), 32'd0);
      check("hold_valid", 32'(lb_wr_valid), 32'd1);
      check("hold_rob", 32'(lb_wr_rob_idx), 32'd1);
      check("hold_value", lb_wr_value, 32'h1111_1111);
      tick();
    end
    idle(); mem2lb_data = 32'h2222_2222; #1;
    check("release_issue", 32'(lb_read_mem), 32'd1);
    check("release_addr", lb2mem_addr, 32'h44);
    tick();
    check("release_rob", 32'(lb_wr_rob_idx), 32'd2);
    check("release_value", lb_wr_value, 32'h2222_2222);
    tick();

    // Flush with 3 pending entries and a held result
    idle();
    set_alloc(32'h80, 2'd2, 1'b0, 5'd20, 3'd0);
    mem2lb_data = 32'h0BAD_F00D;
    tick();
    set_alloc(32'h84, 2'd2, 1'b0, 5'd21, 3'd3);
    tick();
    set_alloc(32'h88, 2'd2, 1'b0, 5'd22, 3'd3);
    lb_exec_stall = 1'b1; lb_wr_enable = 1'b0;
    tick();
    set_alloc(32'h8C, 2'd2, 1'b0, 5'd23, 3'd3);
    tick();
    idle();
    set_alloc(32'h90, 2'd2, 1'b0, 5'd24, 3'd0);
    branch_misprediction = 1'b1; lb_wr_enable = 1'b0;
    #1;
    check("pre_flush_wr_valid", 32'(lb_wr_valid), 32'd1);
    check("pre_flush_wr_rob", 32'(lb_wr_rob_idx), 32'd20);
    check("flush_no_issue", 32'(lb_read_mem), 32'd0);
    tick();
    idle(); commit_wr_mem = 1'b1; #1;
    check("post_flush_full", 32'(lb_full), 32'd0);
    check("post_flush_wr_valid", 32'(lb_wr_valid), 32'd0);
    check("post_flush_alloc_dropped", 32'(lb_read_mem), 32'd0);
    tick(); tick();
    #1;
    check("post_flush_entries_gone", 32'(lb_read_mem), 32'd0);
    tick();
    idle(); #1;
    check("post_flush_still_empty", 32'(lb_read_mem), 32'd0);
    tick();

    // Reset mid-operation discards pending entry and result
    idle();
    set_alloc(32'hC0, 2'd2, 1'b0, 5'd30, 3'd0);
    tick();
    idle(); lb_wr_enable = 1'b0; #1;
    check("midrst_pre_issue", 32'(lb_read_mem), 32'd1);
    set_alloc(32'hC4, 2'd2, 1'b0, 5'd31, 3'd1);
    tick();
    idle(); reset = 1'b1;
    tick();
    idle(); commit_wr_mem = 1'b1; #1;
    check("midrst_wr_valid", 32'(lb_wr_valid), 32'd0);
    check("midrst_wr_rob", 32'(lb_wr_rob_idx), 32'd0);
    check("midrst_wr_value", lb_wr_value, 32'd0);
    check("midrst_full", 32'(lb_full), 32'd0);
    tick();
    idle(); #1;
    check("midrst_no_issue", 32'(lb_read_mem), 32'd0);
    check("midrst_addr_zero", lb2mem_addr, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
